vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
Raster timing generator that drives the VGA pixel interface consumed by the final RGB output multiplexer. It produces pix_x, pix_y and video_on for the pixel selector, plus hsync/vsync to the connector. The sync outputs are delayed to stay aligned with the selector's registered RGB output. A pixel-enable tick is derived from the 100 MHz system clock, and frame/line markers are provided for the RTC/PicoBlaze display logic.

Parameters:
CLK_DIV, 4, system clocks per pixel (1..8); 100 MHz/4 = 25 MHz pixel rate
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, asserted sync level (0 = active-low)
PIPE_DLY, 1, clk-cycle delay applied to hsync/vsync (0..3); 1 matches the selector's output register

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
p_tick  out  1  one-clk pixel enable, every CLK_DIV clocks
pix_x  out  10  current horizontal count, 0..H_TOTAL-1
pix_y  out  10  current vertical count, 0..V_TOTAL-1
video_on  out  1  pixel lies inside the active area
hsync  out  1  horizontal sync, polarity SYNC_POL, delayed PIPE_DLY clks
vsync  out  1  vertical sync, polarity SYNC_POL, delayed PIPE_DLY clks
line_end  out  1  one-clk pulse on the last pixel tick of each line
frame_end  out  1  one-clk pulse on the last pixel tick of each frame

Behaviour:
- Interface: reset is named reset and is synchronous, active-high; the clock is clk.
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset (while reset=1):
  - div_cnt, h_count, v_count = 0; run = 0.
  - p_tick, video_on, line_end, frame_end = 0; pix_x = pix_y = 0.
  - hsync and vsync, including every delay stage, = ~SYNC_POL (deasserted).
- run flag: register set to 1 on the first clk edge with reset=0 and held until the next reset.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - p_tick = run && (div_cnt == CLK_DIV-1).
  - With CLK_DIV=1, p_tick = run, i.e. continuous after the first post-reset cycle.
- Counters advance only on a clk edge where p_tick=1:
  - h_count increments; at H_TOTAL-1 it wraps to 0 and v_count increments.
  - v_count wraps to 0 at V_TOTAL-1 when h_count also wraps.
- Outputs are combinational from the registered counters, so they carry zero latency relative to pix_x/pix_y:
  - pix_x = h_count; pix_y = v_count.
  - video_on = run && h_count < H_ACTIVE && v_count < V_ACTIVE.
  - line_end = p_tick && h_count == H_TOTAL-1.
  - frame_end = line_end && v_count == V_TOTAL-1.
- Sync generation:
  - hsync_raw is asserted for H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync_raw is asserted for V_ACTIVE+V_FP <= v_count < V_ACTIVE+V_FP+V_SYNC (490..491).
  - Both pass through a PIPE_DLY-deep clk-rate shift register; PIPE_DLY=0 means a direct combinational output.
  - The delay is applied per clk, not per p_tick, because the downstream RGB register is clk-rate.
- Timing invariants: no glitches; each pixel lasts exactly CLK_DIV clks; one frame is H_TOTAL*V_TOTAL*CLK_DIV clks (1,680,000 at defaults).
- Reset mid-frame:
  - All state returns to reset values on the same edge; no partial line is emitted.
  - After release, timing restarts from (0,0) with the first p_tick CLK_DIV clks later.
- Parameter legality: H_TOTAL-1 and V_TOTAL-1 must fit in 10 bits. The elaboration check fails if either exceeds 1023 or if CLK_DIV = 0.

Decomposition:
- Package vga_timing_pkg holds:
  - default 640x480@60 timing constants;
  - the H_TOTAL/V_TOTAL and sync-window start/end derivation functions;
  - the 10-bit coordinate width constant, shared with the RGB selector's region decodes.
- Sub-module pixel_tick_div (div_cnt plus p_tick) is natural and reusable by the text/image ROM address logic.

Test Plan:
- Reset release, defaults: first p_tick at clk 4 after reset falls; pix_x becomes 1 on the following edge; video_on=1 from clk 1 at (0,0); hsync/vsync read 1 during reset.
- Line timing: measure hsync low width = 96*4 = 384 clks; falling edge when pix_x=656, delayed 1 clk; line_end period = 3200 clks; video_on high 2560 clks per active line.
- Frame timing: vsync low for exactly 2 lines (6400 clks) beginning at pix_y=490; frame_end period = 1,680,000 clks; video_on=0 for all of pix_y 480..524.
- Wrap-around: at (799,524) with p_tick, frame_end=1 and line_end=1 in the same clk; the next edge gives pix_x=0, pix_y=0, video_on=1.
- Reset mid-frame at pix_x=300, pix_y=200: next edge gives counters 0, video_on=0, syncs deasserted; after release the sequence is identical to the first scenario.
- Parameter sweep: CLK_DIV=1 gives p_tick continuous after the run cycle, and a frame = 420,000 clks. SYNC_POL=1 inverts the sync levels. PIPE_DLY=0 and PIPE_DLY=3 shift the hsync edge relative to pix_x by 0 and 3 clks respectively.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 VGA timing and the window derivations shared by the sync
// generator and the RGB selector's region decodes.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int line_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int sync_start(input int active, input int fp);
        return active + fp;
    endfunction

    function automatic int sync_end(input int active, input int fp, input int sync);
        return active + fp + sync;
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Pixel-enable divider: one-clk p_tick every CLK_DIV clocks once the run flag
// has been set by the first cycle out of reset.
module pixel_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic run,
    output logic p_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    // div_cnt holds at 0 until run is set, so the first tick lands CLK_DIV clks after release
    always_ff @(posedge clk) begin
        if (reset) begin
            run     <= 1'b0;
            div_cnt <= '0;
        end else begin
            run <= 1'b1;
            if (run) begin
                div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            end
        end
    end

    assign p_tick = run && (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel/line counters, active-video decode, line and
// frame markers, and clk-rate delayed sync outputs for the VGA connector.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0,
    parameter int PIPE_DLY = 1
) (
    input  logic               clk,
    input  logic               reset,
    output logic               p_tick,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               line_end,
    output logic               frame_end
);

    localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int CW1     = COORD_W + 1;

    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
    localparam logic [CW1-1:0] H_ACT_C = CW1'(H_ACTIVE);
    localparam logic [CW1-1:0] V_ACT_C = CW1'(V_ACTIVE);
    localparam logic [CW1-1:0] HS_ON   = CW1'(sync_start(H_ACTIVE, H_FP));
    localparam logic [CW1-1:0] HS_OFF  = CW1'(sync_end(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [CW1-1:0] VS_ON   = CW1'(sync_start(V_ACTIVE, V_FP));
    localparam logic [CW1-1:0] VS_OFF  = CW1'(sync_end(V_ACTIVE, V_FP, V_SYNC));

    generate
        if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W) || CLK_DIV == 0) begin : g_bad_params
            $error("vga_sync_gen: timing does not fit the coordinate width or CLK_DIV is zero");
        end
    endgenerate

    logic               run;
    logic [COORD_W-1:0] h_count;
    logic [COORD_W-1:0] v_count;
    logic [CW1-1:0]     h_ext;
    logic [CW1-1:0]     v_ext;
    logic               hsync_lvl;
    logic               vsync_lvl;

    pixel_tick_div #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .p_tick(p_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
        end else if (p_tick) begin
            if (h_count == H_LAST) begin
                h_count <= '0;
                v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
            end else begin
                h_count <= h_count + 1'b1;
            end
        end
    end

    // Extended by one bit so a sync window ending exactly at 2**COORD_W still compares correctly
    assign h_ext = {1'b0, h_count};
    assign v_ext = {1'b0, v_count};

    assign pix_x     = h_count;
    assign pix_y     = v_count;
    assign video_on  = run && (h_ext < H_ACT_C) && (v_ext < V_ACT_C);
    assign line_end  = p_tick && (h_count == H_LAST);
    assign frame_end = line_end && (v_count == V_LAST);

    assign hsync_lvl = (h_ext >= HS_ON && h_ext < HS_OFF) ? SYNC_POL : ~SYNC_POL;
    assign vsync_lvl = (v_ext >= VS_ON && v_ext < VS_OFF) ? SYNC_POL : ~SYNC_POL;

    // Syncs are delayed at clk rate to line up with the selector's registered RGB
    generate
        if (PIPE_DLY == 0) begin : g_direct
            assign hsync = hsync_lvl;
            assign vsync = vsync_lvl;
        end else begin : g_delay
            logic [PIPE_DLY-1:0] hsync_dly;
            logic [PIPE_DLY-1:0] vsync_dly;

            always_ff @(posedge clk) begin
                if (reset) begin
                    hsync_dly <= {PIPE_DLY{~SYNC_POL}};
                    vsync_dly <= {PIPE_DLY{~SYNC_POL}};
                end else begin
                    hsync_dly <= (hsync_dly << 1) | PIPE_DLY'(hsync_lvl);
                    vsync_dly <= (vsync_dly << 1) | PIPE_DLY'(vsync_lvl);
                end
            end

            assign hsync = hsync_dly[PIPE_DLY-1];
            assign vsync = vsync_dly[PIPE_DLY-1];
        end
    endgenerate

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three reduced-timing instances covering CLK_DIV,
// SYNC_POL and PIPE_DLY variants, checked against a cycle-count timing model.
module tb_vga_sync_gen;

    localparam int HA = 8, HFP = 2, HSW = 3, HBP = 3, HT = 16;
    localparam int VA = 4, VFP = 1, VSW = 2, VBP = 1, VT = 8;
    localparam int HS_ON = 10, HS_OFF = 13, VS_ON = 5, VS_OFF = 7;

    typedef struct packed {
        logic       p_tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       vo;
        logic       hs;
        logic       vs;
        logic       le;
        logic       fe;
    } out_t;

    typedef struct packed {
        out_t a;
        out_t b;
        out_t c;
    } exp_t;

    typedef struct {
        logic       rst;
        logic       p_tick;
        logic [9:0] x;
        logic       vo;
        logic       hs;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic       a_pt, a_vo, a_hs, a_vs, a_le, a_fe;
    logic [9:0] a_x, a_y;
    logic       b_pt, b_vo, b_hs, b_vs, b_le, b_fe;
    logic [9:0] b_x, b_y;
    logic       c_pt, c_vo, c_hs, c_vs, c_le, c_fe;
    logic [9:0] c_x, c_y;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_edges = 0;
    int   cyc = 0;
    exp_t sbq[$];
    vec_t tbl[10];

    always #5 clk = ~clk;

    vga_sync_gen #(
        .CLK_DIV(4), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SYNC_POL(1'b0), .PIPE_DLY(1)
    ) dut_a (
        .clk(clk), .reset(reset), .p_tick(a_pt), .pix_x(a_x), .pix_y(a_y),
        .video_on(a_vo), .hsync(a_hs), .vsync(a_vs), .line_end(a_le), .frame_end(a_fe)
    );

    vga_sync_gen #(
        .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SYNC_POL(1'b1), .PIPE_DLY(3)
    ) dut_b (
        .clk(clk), .reset(reset), .p_tick(b_pt), .pix_x(b_x), .pix_y(b_y),
        .video_on(b_vo), .hsync(b_hs), .vsync(b_vs), .line_end(b_le), .frame_end(b_fe)
    );

    vga_sync_gen #(
        .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SYNC_POL(1'b0), .PIPE_DLY(0)
    ) dut_c (
        .clk(clk), .reset(reset), .p_tick(c_pt), .pix_x(c_x), .pix_y(c_y),
        .video_on(c_vo), .hsync(c_hs), .vsync(c_vs), .line_end(c_le), .frame_end(c_fe)
    );

    // n = clk edges seen with reset low since the last reset; pixel index follows from n and d
    function automatic out_t model(input int n, input int d, input bit pol, input int dly);
        out_t o;
        int   pc, m, pcm, xs, ys;
        logic run;
        run      = (n >= 1);
        pc       = run ? (n - 1) / d : 0;
        o.x      = 10'(pc % HT);
        o.y      = 10'((pc / HT) % VT);
        o.p_tick = run && (((n - 1) % d) == d - 1);
        o.vo     = run && (int'(o.x) < HA) && (int'(o.y) < VA);
        o.le     = o.p_tick && (int'(o.x) == HT - 1);
        o.fe     = o.le && (int'(o.y) == VT - 1);
        m        = (n - dly < 0) ? 0 : n - dly;
        pcm      = (m >= 1) ? (m - 1) / d : 0;
        xs       = pcm % HT;
        ys       = (pcm / HT) % VT;
        o.hs     = (xs >= HS_ON && xs < HS_OFF) ? pol : ~pol;
        o.vs     = (ys >= VS_ON && ys < VS_OFF) ? pol : ~pol;
        return o;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got 0x%0h, wanted 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic r);
        exp_t e;
        out_t oa, ob, oc;
        reset   = r;
        n_edges = r ? 0 : n_edges + 1;
        e.a = model(n_edges, 4, 1'b0, 1);
        e.b = model(n_edges, 1, 1'b1, 3);
        e.c = model(n_edges, 2, 1'b0, 0);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e  = sbq.pop_front();
        oa = {a_pt, a_x, a_y, a_vo, a_hs, a_vs, a_le, a_fe};
        ob = {b_pt, b_x, b_y, b_vo, b_hs, b_vs, b_le, b_fe};
        oc = {c_pt, c_x, c_y, c_vo, c_hs, c_vs, c_le, c_fe};
        check("sb_a", int'(oa), int'(e.a));
        check("sb_b", int'(ob), int'(e.b));
        check("sb_c", int'(oc), int'(e.c));
    endtask

    task automatic apply_table();
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].rst);
            check("tbl_ptick", int'(a_pt), int'(tbl[i].p_tick));
            check("tbl_x", int'(a_x), int'(tbl[i].x));
            check("tbl_video_on", int'(a_vo), int'(tbl[i].vo));
            check("tbl_hsync", int'(a_hs), int'(tbl[i].hs));
        end
    endtask

    initial begin
        int   t_fall, hs_w, fall_x_a, rise_x_b, fall_x_c;
        int   le1, le2, fa1, fa2, fb1, fb2, vs_lo, vo_cnt, vo_bad, pt_gap;
        logic pa, pb, pcc, wrap_chk, found;

        // reset, reset, then release: run at clk 1, first tick at clk 4, pix_x=1 at clk 5
        tbl[0] = '{1'b1, 1'b0, 10'd0, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 10'd0, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 10'd0, 1'b1, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 10'd0, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 10'd0, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 10'd0, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 10'd1, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 10'd1, 1'b1, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 10'd1, 1'b1, 1'b1};
        tbl[9] = '{1'b0, 1'b1, 10'd1, 1'b1, 1'b1};

        apply_table();

        // hsync edge position and width, plus the PIPE_DLY=3 / PIPE_DLY=0 shifts
        pa = a_hs; pb = b_hs; pcc = c_hs;
        t_fall = -1; hs_w = 0; fall_x_a = -1; rise_x_b = -1; fall_x_c = -1;
        for (int i = 0; i < 300; i++) begin
            step(1'b0);
            if (pa && !a_hs && t_fall < 0) begin
                t_fall   = i;
                fall_x_a = int'(a_x);
            end
            if (t_fall >= 0 && !a_hs) hs_w++;
            if (!pb && b_hs && rise_x_b < 0) rise_x_b = int'(b_x);
            if (pcc && !c_hs && fall_x_c < 0) fall_x_c = int'(c_x);
            pa = a_hs; pb = b_hs; pcc = c_hs;
            if (t_fall >= 0 && a_hs && rise_x_b >= 0 && fall_x_c >= 0) break;
        end
        check("hs_fall_x_a", fall_x_a, HS_ON);
        check("hs_width_a", hs_w, HSW * 4);
        check("hs_assert_x_b", rise_x_b, HS_ON + 3);
        check("hs_fall_x_c", fall_x_c, HS_ON);

        // line/frame periods, vsync width, active-video accounting, wrap-around
        le1 = -1; le2 = -1; fa1 = -1; fa2 = -1; fb1 = -1; fb2 = -1;
        vs_lo = 0; vo_cnt = 0; vo_bad = 0; pt_gap = 0; wrap_chk = 1'b0;
        for (int i = 0; i < 1300 && fa2 < 0; i++) begin
            step(1'b0);
            if (wrap_chk) begin
                check("wrap_x", int'(a_x), 0);
                check("wrap_y", int'(a_y), 0);
                check("wrap_video_on", int'(a_vo), 1);
                wrap_chk = 1'b0;
            end
            if (a_le) begin
                if (le1 < 0) le1 = i;
                else if (le2 < 0) le2 = i;
            end
            if (b_fe) begin
                if (fb1 < 0) fb1 = i;
                else if (fb2 < 0) fb2 = i;
            end
            if (!b_pt) pt_gap++;
            if (fa1 >= 0) begin
                if (!a_vs) vs_lo++;
                if (a_vo) vo_cnt++;
                if (a_vo && int'(a_y) >= VA) vo_bad++;
            end
            if (a_fe) begin
                if (fa1 < 0) begin
                    fa1 = i;
                    check("wrap_line_end", int'(a_le), 1);
                    check("wrap_pos", int'({a_x, a_y}), (HT - 1) * 1024 + (VT - 1));
                    wrap_chk = 1'b1;
                end else begin
                    fa2 = i;
                end
            end
        end
        check("line_period_a", le2 - le1, HT * 4);
        check("frame_period_a", fa2 - fa1, HT * VT * 4);
        check("frame_period_b", fb2 - fb1, HT * VT);
        check("ptick_gaps_b", pt_gap, 0);
        check("vsync_low_a", vs_lo, VSW * HT * 4);
        check("video_on_clks_a", vo_cnt, HA * VA * 4);
        check("video_on_blank_a", vo_bad, 0);

        // reset mid-frame at a chosen raster position
        found = 1'b0;
        for (int i = 0; i < 700 && !found; i++) begin
            step(1'b0);
            if (a_x == 10'd5 && a_y == 10'd2) found = 1'b1;
        end
        check("mid_pos_found", int'(found), 1);
        step(1'b1);
        check("mid_rst_x", int'(a_x), 0);
        check("mid_rst_y", int'(a_y), 0);
        check("mid_rst_video_on", int'(a_vo), 0);
        check("mid_rst_ptick", int'(a_pt), 0);
        check("mid_rst_hsync_a", int'(a_hs), 1);
        check("mid_rst_vsync_a", int'(a_vs), 1);
        check("mid_rst_hsync_b", int'(b_hs), 0);
        check("mid_rst_vsync_b", int'(b_vs), 0);

        apply_table();
        for (int i = 0; i < 600; i++) step(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
